serial_to_parallel_receiver: RTL and testbench
==============================================

Name: serial_to_parallel_receiver

Overview:
Receive end of the parallel-to-serial link. Deserialises a valid-qualified serial stream, MSB first, into a WIDTH-bit parallel word. Holds the word for the downstream consumer until it is acknowledged. Flags framing loss and overrun. Sits directly on the serial data line and the valid (VO) line of the link transmitter controller.

Parameters:
WIDTH, 8, bits per word; legal range 2..32; the serial stream carries bit WIDTH-1 first.

Ports:
ck  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
din  input  1  serial data bit, sampled when vi=1
vi  input  1  valid-in from the transmitter; high for exactly one contiguous frame
ack  input  1  consumer acknowledge of the held word
dout  output  WIDTH  assembled word; stable while valid=1
valid  output  1  word available, level, held until ack
busy  output  1  high while a frame is being received (state RECV)
frame_err  output  1  one-cycle pulse: vi dropped mid-frame
overrun  output  1  sticky: vi rose while a word was held and not acked
parity_err  output  1  parity mismatch on the held word; tied 0 unless PARITY_EN

Behaviour:
- Reset (ck edge with reset=1) takes priority over everything, including mid-frame:
  - state=IDLE, bit counter=0, shift register=0, dout=0.
  - valid, busy, frame_err, overrun and parity_err all 0.
  - A partial frame is discarded.
- State encoding is one-hot: IDLE=3'b001, RECV=3'b010, HOLD=3'b100. Any illegal state returns to IDLE on the next edge.
- Bit counter width is $clog2(WIDTH+2). Frame length F=WIDTH, or WIDTH+1 with PARITY_EN.
- IDLE:
  - vi=1: shift in din as the first bit, counter=1, go to RECV.
  - vi=0: hold.
- RECV:
  - Each edge with vi=1: shift register <= {shift[WIDTH-2:0], din}, counter+1.
  - On the edge that captures bit F:
    - dout <= assembled word, valid<=1, counter<=0, go to HOLD.
    - Latency: valid and dout are visible the cycle after the last bit is presented.
  - vi=0 while counter<F:
    - frame_err=1 for exactly one cycle; counter<=0; go to IDLE.
    - dout and valid are unchanged.
- busy=1 exactly while state=RECV.
- HOLD:
  - valid=1; din is ignored.
  - ack=1, vi=0: valid<=0, go to IDLE.
  - ack=1 and vi=1 in the same cycle: treat as back-to-back. valid<=0, capture din as the first bit, counter=1, go to RECV. No overrun.
  - ack=0, vi=1: overrun<=1 (sticky until reset). Stay in HOLD; dout is preserved and incoming bits are dropped.
  - After such an overrun, vi must return low before a new frame is accepted. An ack while vi is still high returns to IDLE, and the remainder of that frame is ignored until vi has been seen low for one cycle.
- ack in IDLE or RECV has no effect.
- With WIDTH=8, din is sourced in the order sel=7..0, so dout[7] is the first bit received.

Optional Feature:
PARITY_EN
- Defined:
  - Frame is WIDTH data bits followed by one even-parity bit, i.e. XOR of data and parity bit must be 0.
  - The parity bit is not stored in dout.
  - On the HOLD-entry edge, parity_err <= mismatch; it is cleared together with valid.
  - vi dropping before the parity bit raises frame_err.
- Undefined: frame is WIDTH bits; parity_err is constant 0.

Test Plan:
- Basic word: reset, then vi=1 for 8 cycles with din=1,0,1,0,0,1,0,1.
  -> valid=1 the cycle after the 8th bit; dout=8'hA5; busy high for 7 cycles; frame_err=0.
- Framing loss: vi=1 for 4 bits (1,1,0,0), then vi=0.
  -> frame_err pulses 1 cycle; valid stays 0; dout stays 8'h00. A following full 8'h3C frame is received correctly.
- Back-to-back: after 8'hA5 is held, assert ack and start the next frame (8'h5A) in the same cycle.
  -> valid drops 1 cycle; 8'h5A is held 8 cycles later; overrun=0.
- Overrun: hold 8'hFF with ack=0, then send 8'h00.
  -> overrun=1 and stays 1; dout remains 8'hFF. After ack, vi low, and a new frame 8'h81: dout=8'h81 and overrun is still 1.
- Reset mid-frame: reset for 1 cycle after 5 bits of 8'hC3.
  -> all outputs 0 next cycle. A fresh full 8'hC3 frame yields dout=8'hC3.
- PARITY_EN: send 8'hA5 with parity 0 -> parity_err=0. Send 8'hA5 with parity 1 -> parity_err=1 alongside valid; cleared on ack.

Source files
------------

// File: rtl/serial_to_parallel_receiver.sv
// Purpose: deserialise a valid-qualified MSB-first serial stream into a WIDTH-bit word.
// Latency: dout/valid update on the edge that captures the last frame bit (visible next cycle).
// Backpressure: word held until ack; a frame arriving while held is dropped and flags overrun.
//
// Ports:
//   ck, reset       clock and synchronous active-high reset
//   din, vi         serial data bit and its valid (one contiguous frame per vi pulse)
//   ack             consumer acknowledge of the held word
//   dout, valid     held parallel word and its level-valid
//   busy            frame reception in progress
//   frame_err       one-cycle pulse when vi drops mid-frame
//   overrun         sticky: a frame started while a word was still held
//   parity_err      even-parity mismatch on the held word
// Optional feature macro: PARITY_EN (adds one trailing even-parity bit per frame).
module serial_to_parallel_receiver #(
  parameter int WIDTH = 8
) (
  input  logic             ck,
  input  logic             reset,
  input  logic             din,
  input  logic             vi,
  input  logic             ack,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 2);
`ifdef PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif
  localparam logic [CW-1:0] LAST = CW'(FLEN - 1);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    RECV = 3'b010,
    HOLD = 3'b100
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] word;
  // Set when a frame was refused during HOLD; no new frame is accepted
  // until vi has been sampled low once.
  logic             wait_low;

  logic take_first, take_bit, finish, drop_valid, set_ovr, abort;

  always_ff @(posedge ck) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    take_first = 1'b0;
    take_bit   = 1'b0;
    finish     = 1'b0;
    drop_valid = 1'b0;
    set_ovr    = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (vi && !wait_low) begin
          take_first = 1'b1;
          state_nxt  = RECV;
        end
      end
      RECV: begin
        if (vi) begin
          take_bit = 1'b1;
          if (cnt == LAST) begin
            finish    = 1'b1;
            state_nxt = HOLD;
          end
        end else begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (ack) begin
          drop_valid = 1'b1;
          // Back-to-back start only for a fresh frame, not the tail of a refused one.
          if (vi && !wait_low) begin
            take_first = 1'b1;
            state_nxt  = RECV;
          end else begin
            state_nxt = IDLE;
          end
        end else if (vi) begin
          set_ovr = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RECV);

`ifdef PARITY_EN
  // On the final edge din is the parity bit; the data bits are all in shift.
  assign word = shift;

  always_ff @(posedge ck) begin
    if (reset)           parity_err <= 1'b0;
    else if (finish)     parity_err <= (^shift) ^ din;
    else if (drop_valid) parity_err <= 1'b0;
  end
`else
  assign word       = {shift[WIDTH-2:0], din};
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge ck) begin
    if (reset) begin
      cnt       <= '0;
      shift     <= '0;
      dout      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      wait_low  <= 1'b0;
    end else begin
      frame_err <= abort;
      if (set_ovr) overrun <= 1'b1;

      if (!vi)          wait_low <= 1'b0;
      else if (set_ovr) wait_low <= 1'b1;

      if (take_first) begin
        shift <= {shift[WIDTH-2:0], din};
        cnt   <= CW'(1);
      end else if (take_bit) begin
        shift <= {shift[WIDTH-2:0], din};
        cnt   <= finish ? '0 : cnt + CW'(1);
      end else if (abort) begin
        cnt <= '0;
      end

      if (finish) begin
        dout  <= word;
        valid <= 1'b1;
      end else if (drop_valid) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_receiver.sv
// Purpose: self-checking bench for serial_to_parallel_receiver (WIDTH=8).
// Latency: directed scenarios followed by randomized frame-level traffic.
// Backpressure: exercises ack, back-to-back, overrun and refused-frame recovery.
module tb_serial_to_parallel_receiver;

`ifdef PARITY_EN
  localparam int FL  = 9;
  localparam bit PAR = 1'b1;
`else
  localparam int FL  = 8;
  localparam bit PAR = 1'b0;
`endif

  logic       ck = 1'b0;
  logic       reset, din, vi, ack;
  logic [7:0] dout;
  logic       valid, busy, frame_err, overrun, parity_err;

  int checks   = 0;
  int failures = 0;

  serial_to_parallel_receiver #(.WIDTH(8)) dut (
    .ck(ck), .reset(reset), .din(din), .vi(vi), .ack(ack),
    .dout(dout), .valid(valid), .busy(busy), .frame_err(frame_err),
    .overrun(overrun), .parity_err(parity_err)
  );

  always #5 ck = ~ck;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  // Drives the first nbits of a frame (data MSB first, then even parity when
  // enabled). ack is raised only on bit index ack_at.
  task automatic send_frame(input logic [7:0] w, input int nbits, input int ack_at,
                            input logic par_flip, output int busy_cnt, output logic v_first);
    logic [8:0] bits;
    bits     = {w, (^w) ^ par_flip};
    busy_cnt = 0;
    v_first  = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      vi  = 1'b1;
      din = bits[8-i];
      ack = (i == ack_at);
      tick();
      if (busy) busy_cnt++;
      if (i == 0) v_first = valid;
    end
    vi  = 1'b0;
    ack = 1'b0;
    din = 1'b0;
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    vi  = 1'b0;
    tick();
    ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int         bc;
    logic       vf;
    logic [7:0] exp_dout;
    logic       exp_valid, exp_ovr, exp_perr;

    reset = 1'b1; vi = 1'b0; din = 1'b0; ack = 1'b0;
    tick();
    tick();
    check_eq("rst_dout", 32'(dout), 32'(0));
    check_eq("rst_valid", 32'(valid), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_flags", 32'({frame_err, overrun, parity_err}), 32'(0));
    reset = 1'b0;

    // Basic word
    send_frame(8'hA5, FL, -1, 1'b0, bc, vf);
    check_eq("basic_valid", 32'(valid), 32'(1));
    check_eq("basic_dout", 32'(dout), 32'(8'hA5));
    check_eq("basic_busy_cycles", 32'(bc), 32'(FL - 1));
    check_eq("basic_ferr", 32'(frame_err), 32'(0));
    check_eq("basic_perr", 32'(parity_err), 32'(0));
    tick();
    check_eq("basic_valid_held", 32'(valid), 32'(1));
    ack_pulse();
    check_eq("basic_ack_clears", 32'(valid), 32'(0));

    // Framing loss
    do_reset();
    send_frame(8'hC0, 4, -1, 1'b0, bc, vf);
    tick();
    check_eq("ferr_pulse", 32'(frame_err), 32'(1));
    check_eq("ferr_valid", 32'(valid), 32'(0));
    check_eq("ferr_dout", 32'(dout), 32'(0));
    tick();
    check_eq("ferr_one_cycle", 32'(frame_err), 32'(0));
    send_frame(8'h3C, FL, -1, 1'b0, bc, vf);
    check_eq("after_ferr_dout", 32'(dout), 32'(8'h3C));
    check_eq("after_ferr_valid", 32'(valid), 32'(1));

    // Back-to-back
    ack_pulse();
    send_frame(8'hA5, FL, -1, 1'b0, bc, vf);
    send_frame(8'h5A, FL, 0, 1'b0, bc, vf);
    check_eq("b2b_valid_drop", 32'(vf), 32'(0));
    check_eq("b2b_valid", 32'(valid), 32'(1));
    check_eq("b2b_dout", 32'(dout), 32'(8'h5A));
    check_eq("b2b_overrun", 32'(overrun), 32'(0));

    // Overrun
    ack_pulse();
    send_frame(8'hFF, FL, -1, 1'b0, bc, vf);
    send_frame(8'h00, FL, -1, 1'b0, bc, vf);
    tick();
    check_eq("ovr_flag", 32'(overrun), 32'(1));
    check_eq("ovr_dout", 32'(dout), 32'(8'hFF));
    check_eq("ovr_valid", 32'(valid), 32'(1));
    ack_pulse();
    tick();
    send_frame(8'h81, FL, -1, 1'b0, bc, vf);
    check_eq("ovr_new_dout", 32'(dout), 32'(8'h81));
    check_eq("ovr_sticky", 32'(overrun), 32'(1));

    // Ack in the middle of a refused frame: its tail must be ignored.
    send_frame(8'h00, FL, 3, 1'b0, bc, vf);
    check_eq("refused_valid", 32'(valid), 32'(0));
    check_eq("refused_busy", 32'(bc), 32'(0));
    check_eq("refused_dout", 32'(dout), 32'(8'h81));
    tick();
    send_frame(8'h5A, FL, -1, 1'b0, bc, vf);
    check_eq("recover_dout", 32'(dout), 32'(8'h5A));
    check_eq("recover_valid", 32'(valid), 32'(1));

    // Reset mid-frame
    ack_pulse();
    send_frame(8'hC3, 5, -1, 1'b0, bc, vf);
    check_eq("mid_busy", 32'(busy), 32'(1));
    do_reset();
    check_eq("mid_rst_dout", 32'(dout), 32'(0));
    check_eq("mid_rst_ctl", 32'({valid, busy, frame_err, overrun, parity_err}), 32'(0));
    send_frame(8'hC3, FL, -1, 1'b0, bc, vf);
    check_eq("mid_rst_fresh", 32'(dout), 32'(8'hC3));

`ifdef PARITY_EN
    ack_pulse();
    send_frame(8'hA5, FL, -1, 1'b0, bc, vf);
    check_eq("par_good", 32'(parity_err), 32'(0));
    ack_pulse();
    send_frame(8'hA5, FL, -1, 1'b1, bc, vf);
    check_eq("par_bad", 32'({valid, parity_err}), 32'(2'b11));
    ack_pulse();
    check_eq("par_clear", 32'({valid, parity_err}), 32'(0));
`endif

    // Randomized traffic against a frame-level model
    do_reset();
    exp_dout = '0; exp_valid = 1'b0; exp_ovr = 1'b0; exp_perr = 1'b0;
    for (int it = 0; it < 60; it++) begin
      int         kind, n;
      logic [7:0] w;
      logic       flip;
      kind = int'($urandom_range(0, 3));
      w    = 8'($urandom);
      flip = 1'($urandom_range(0, 1));
      case (kind)
        0: begin
          if (exp_valid) begin
            ack_pulse();
            exp_valid = 1'b0;
            exp_perr  = 1'b0;
          end
          send_frame(w, FL, -1, flip, bc, vf);
          exp_valid = 1'b1;
          exp_dout  = w;
          exp_perr  = PAR & flip;
        end
        1: begin
          if (exp_valid) begin
            ack_pulse();
            exp_valid = 1'b0;
            exp_perr  = 1'b0;
          end
          n = int'($urandom_range(1, FL - 1));
          send_frame(w, n, -1, flip, bc, vf);
          tick();
          check_eq("rnd_ferr", 32'(frame_err), 32'(1));
        end
        2: begin
          if (exp_valid) begin
            send_frame(w, FL, 0, flip, bc, vf);
            check_eq("rnd_b2b_drop", 32'(vf), 32'(0));
          end else begin
            send_frame(w, FL, -1, flip, bc, vf);
          end
          exp_valid = 1'b1;
          exp_dout  = w;
          exp_perr  = PAR & flip;
        end
        default: begin
          if (!exp_valid) begin
            send_frame(w, FL, -1, flip, bc, vf);
            exp_valid = 1'b1;
            exp_dout  = w;
            exp_perr  = PAR & flip;
            w         = ~w;
          end
          send_frame(w, FL, -1, 1'b0, bc, vf);
          exp_ovr = 1'b1;
          tick();
        end
      endcase
      n = int'($urandom_range(0, 2));
      for (int g = 0; g < n; g++) tick();
      check_eq("rnd_valid", 32'(valid), 32'(exp_valid));
      if (exp_valid) check_eq("rnd_dout", 32'(dout), 32'(exp_dout));
      check_eq("rnd_overrun", 32'(overrun), 32'(exp_ovr));
      check_eq("rnd_perr", 32'(parity_err), 32'(exp_perr));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
